// File: rtl/connect_count_accumulator.sv
// Accumulates 2^connectCount per result beat into per-batch sums and queues closed batches in a 4-entry FIFO.
// Optional overflow detection is enabled by defining CONNECT_ACCUM_OVERFLOW_CHECK_EN.
module connect_count_accumulator #(
   parameter int unsigned SUM_WIDTH       = 48,
   parameter int unsigned BOT_COUNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       resultValid,
   input  logic [5:0]                 connectCount,
   input  logic                       isLastBot,
   input  logic                       eccStatusIn,
   output logic                       sumValid,
   input  logic                       sumReady,
   output logic [SUM_WIDTH-1:0]       sumOut,
   output logic [BOT_COUNT_WIDTH-1:0] botCountOut,
   output logic                       eccErrorOut,
   output logic                       overflowOut,
   output logic                       nearlyFull,
   output logic                       resultDropped
);

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTR_W = 2;
   localparam int unsigned CNT_W = 3;

   typedef struct packed {
      logic [SUM_WIDTH-1:0]       sum;
      logic [BOT_COUNT_WIDTH-1:0] cnt;
      logic                       ecc;
      logic                       ovf;
   } batch_t;

   logic                       s1Valid, s1Last, s1TermOvf;
   logic [SUM_WIDTH-1:0]       s1Term;
   logic                       s2Valid, s2Last, s2TermOvf;
   logic [SUM_WIDTH-1:0]       s2Term;

   logic [SUM_WIDTH-1:0]       acc;
   logic [BOT_COUNT_WIDTH-1:0] botCount;
   logic                       eccFlag, ovfFlag;

   logic                       bigCount_c, termOvf_c, addOvf_c;
   logic [SUM_WIDTH-1:0]       term_c, sum_c;
   logic [BOT_COUNT_WIDTH-1:0] cntNext_c;
   batch_t                     closeEntry_c;
   logic                       push_c;

   batch_t                     mem [DEPTH];
   logic [PTR_W-1:0]           wrPtr, rdPtr, rdPtrNext_c;
   logic [CNT_W-1:0]           count, countNext_c;
   logic                       pop_c, full_c, accept_c;
   batch_t                     headNext_c;

   // Term decode; counts past the sum width contribute nothing
   always_comb begin
      bigCount_c = 32'(connectCount) >= SUM_WIDTH;
      term_c     = bigCount_c ? '0 : (SUM_WIDTH'(1) << connectCount);
   end

`ifdef CONNECT_ACCUM_OVERFLOW_CHECK_EN
   logic [SUM_WIDTH:0] sumWide_c;
   assign termOvf_c = bigCount_c;
   assign sumWide_c = {1'b0, acc} + {1'b0, s2Term};
   assign sum_c     = sumWide_c[SUM_WIDTH-1:0];
   assign addOvf_c  = sumWide_c[SUM_WIDTH];
`else
   assign termOvf_c = 1'b0;
   assign sum_c     = acc + s2Term;
   assign addOvf_c  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Valid   <= 1'b0;
         s1Last    <= 1'b0;
         s1Term    <= '0;
         s1TermOvf <= 1'b0;
         s2Valid   <= 1'b0;
         s2Last    <= 1'b0;
         s2Term    <= '0;
         s2TermOvf <= 1'b0;
      end else begin
         s1Valid   <= resultValid;
         s1Last    <= isLastBot;
         s1Term    <= term_c;
         s1TermOvf <= termOvf_c;
         s2Valid   <= s1Valid;
         s2Last    <= s1Last;
         s2Term    <= s1Term;
         s2TermOvf <= s1TermOvf;
      end
   end

   // Closing beat's ECC includes a pulse arriving in the same cycle
   always_comb begin
      cntNext_c        = (&botCount) ? botCount : botCount + BOT_COUNT_WIDTH'(1);
      closeEntry_c     = '0;
      closeEntry_c.sum = sum_c;
      closeEntry_c.cnt = cntNext_c;
      closeEntry_c.ecc = eccFlag | eccStatusIn;
      closeEntry_c.ovf = ovfFlag | addOvf_c | s2TermOvf;
      push_c           = s2Valid & s2Last;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         botCount <= '0;
         eccFlag  <= 1'b0;
         ovfFlag  <= 1'b0;
      end else if (s2Valid && s2Last) begin
         acc      <= '0;
         botCount <= '0;
         eccFlag  <= 1'b0;
         ovfFlag  <= 1'b0;
      end else if (s2Valid) begin
         acc      <= sum_c;
         botCount <= cntNext_c;
         eccFlag  <= closeEntry_c.ecc;
         ovfFlag  <= closeEntry_c.ovf;
      end else begin
         eccFlag  <= eccFlag | eccStatusIn;
      end
   end

   // Head is registered; a push into an emptying slot bypasses storage
   always_comb begin
      pop_c       = sumValid & sumReady;
      full_c      = count == CNT_W'(DEPTH);
      accept_c    = push_c & (~full_c | pop_c);
      rdPtrNext_c = rdPtr + PTR_W'(pop_c);
      countNext_c = count + CNT_W'(accept_c) - CNT_W'(pop_c);
      headNext_c  = (accept_c && (wrPtr == rdPtrNext_c)) ? closeEntry_c : mem[rdPtrNext_c];
   end

   always_ff @(posedge clk) begin
      if (accept_c) mem[wrPtr] <= closeEntry_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr         <= '0;
         rdPtr         <= '0;
         count         <= '0;
         sumValid      <= 1'b0;
         sumOut        <= '0;
         botCountOut   <= '0;
         eccErrorOut   <= 1'b0;
         overflowOut   <= 1'b0;
         nearlyFull    <= 1'b0;
         resultDropped <= 1'b0;
      end else begin
         wrPtr         <= wrPtr + PTR_W'(accept_c);
         rdPtr         <= rdPtrNext_c;
         count         <= countNext_c;
         sumValid      <= countNext_c != '0;
         sumOut        <= headNext_c.sum;
         botCountOut   <= headNext_c.cnt;
         eccErrorOut   <= headNext_c.ecc;
         overflowOut   <= headNext_c.ovf;
         nearlyFull    <= count >= CNT_W'(2);
         resultDropped <= resultDropped | (push_c & full_c & ~pop_c);
      end
   end

endmodule

// File: tb/tb_connect_count_accumulator.sv
// Randomized bench for connect_count_accumulator against a batch-level reference model.
module tb_connect_count_accumulator;

   localparam int unsigned SW = 48;
   localparam int unsigned BW = 16;
`ifdef CONNECT_ACCUM_OVERFLOW_CHECK_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          resultValid = 1'b0;
   logic [5:0]    connectCount = '0;
   logic          isLastBot = 1'b0;
   logic          eccStatusIn = 1'b0;
   logic          sumReady = 1'b0;
   logic          sumValid;
   logic [SW-1:0] sumOut;
   logic [BW-1:0] botCountOut;
   logic          eccErrorOut, overflowOut, nearlyFull, resultDropped;

   connect_count_accumulator #(.SUM_WIDTH(SW), .BOT_COUNT_WIDTH(BW)) dut (
      .clk(clk), .rst(rst), .resultValid(resultValid), .connectCount(connectCount),
      .isLastBot(isLastBot), .eccStatusIn(eccStatusIn), .sumValid(sumValid),
      .sumReady(sumReady), .sumOut(sumOut), .botCountOut(botCountOut),
      .eccErrorOut(eccErrorOut), .overflowOut(overflowOut), .nearlyFull(nearlyFull),
      .resultDropped(resultDropped)
   );

   always #5 clk = ~clk;

   typedef struct { bit v; bit last; int cc; } beat_t;
   typedef struct { logic [SW-1:0] sum; int cnt; bit ecc; bit ovf; } exp_t;

   int testsRun = 0;
   int testsFailed = 0;

   beat_t             beatPipe[$];
   exp_t              fifoQ[$];
   exp_t              seenQ[$];
   longint unsigned   openSum;
   int                openCnt;
   bit                openEcc, openBig, expDropped, expNearlyFull;

   task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic modelClear();
      beatPipe.delete();
      fifoQ.delete();
      openSum = 0; openCnt = 0; openEcc = 0; openBig = 0;
      expDropped = 0; expNearlyFull = 0;
   endtask

   // Batch-level model: a beat counts two edges after it is driven; ECC joins whatever batch is open then
   task automatic modelEdge();
      int    occBefore = fifoQ.size();
      bit    pop = (occBefore != 0) && sumReady;
      bit    doPush = 0;
      exp_t  e = '{default: 0};
      beat_t s;
      beatPipe.push_back('{resultValid, isLastBot, int'(connectCount)});
      openEcc |= eccStatusIn;
      if (beatPipe.size() > 2) begin
         s = beatPipe.pop_front();
         if (s.v) begin
            if (s.cc < int'(SW)) openSum += 64'(1) << s.cc;
            else                 openBig = 1;
            openCnt++;
            if (s.last) begin
               e.sum = openSum[SW-1:0];
               e.cnt = (openCnt > 65535) ? 65535 : openCnt;
               e.ecc = openEcc;
               e.ovf = OVF_EN && ((openSum >> SW) != 0 || openBig);
               if (occBefore == 4 && !pop) expDropped = 1;
               else                        doPush = 1;
               openSum = 0; openCnt = 0; openEcc = 0; openBig = 0;
            end
         end
      end
      if (pop) void'(fifoQ.pop_front());
      if (doPush) fifoQ.push_back(e);
      expNearlyFull = occBefore >= 2;
   endtask

   task automatic checkOutputs();
      checkValue("sumValid", 64'(sumValid), 64'(fifoQ.size() != 0));
      if (fifoQ.size() != 0) begin
         checkValue("sumOut", 64'(sumOut), 64'(fifoQ[0].sum));
         checkValue("botCountOut", 64'(botCountOut), 64'(fifoQ[0].cnt));
         checkValue("eccErrorOut", 64'(eccErrorOut), 64'(fifoQ[0].ecc));
         checkValue("overflowOut", 64'(overflowOut), 64'(fifoQ[0].ovf));
      end
      checkValue("nearlyFull", 64'(nearlyFull), 64'(expNearlyFull));
      checkValue("resultDropped", 64'(resultDropped), 64'(expDropped));
   endtask

   task automatic tick();
      if (sumValid && sumReady) seenQ.push_back('{sumOut, int'(botCountOut), eccErrorOut, overflowOut});
      @(posedge clk);
      modelEdge();
      #1;
      checkOutputs();
   endtask

   task automatic beat(input bit v, input int cc, input bit last, input bit ecc);
      resultValid = v; connectCount = 6'(cc); isLastBot = last; eccStatusIn = ecc;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(0, 0, 0, 0);
   endtask

   task automatic checkSeen(input string tag, input int idx, input longint unsigned sum, input int cnt,
                            input bit ecc, input bit ovf);
      if (idx >= seenQ.size()) begin
         checkValue({tag, " present"}, 64'(seenQ.size()), 64'(idx + 1));
      end else begin
         checkValue({tag, " sum"}, 64'(seenQ[idx].sum), sum);
         checkValue({tag, " cnt"}, 64'(seenQ[idx].cnt), 64'(cnt));
         checkValue({tag, " ecc"}, 64'(seenQ[idx].ecc), 64'(ecc));
         checkValue({tag, " ovf"}, 64'(seenQ[idx].ovf), 64'(ovf));
      end
   endtask

   initial begin
      int mode;
      modelClear();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checkOutputs();

      // Basic batch 0,1,5 and its latency
      sumReady = 1; seenQ.delete();
      beat(1, 0, 0, 0); beat(1, 1, 0, 0); beat(1, 5, 1, 0);
      idle(1);
      checkValue("lat t+2 sumValid", 64'(sumValid), 64'(0));
      idle(1);
      checkValue("lat t+3 sumValid", 64'(sumValid), 64'(1));
      checkValue("lat t+3 sumOut", 64'(sumOut), 64'(35));
      checkValue("lat t+3 botCount", 64'(botCountOut), 64'(3));
      idle(3);

      // Back-to-back batches
      seenQ.delete();
      beat(1, 1, 1, 0); beat(1, 2, 0, 0); beat(1, 3, 1, 0);
      idle(6);
      checkValue("b2b entries", 64'(seenQ.size()), 64'(2));
      checkSeen("b2b first", 0, 2, 1, 0, 0);
      checkSeen("b2b second", 1, 12, 2, 0, 0);

      // Fill with the consumer stalled
      sumReady = 0; seenQ.delete();
      for (int i = 0; i < 5; i++) beat(1, i, 1, 0);
      idle(4);
      checkValue("full nearlyFull", 64'(nearlyFull), 64'(1));
      checkValue("full dropped", 64'(resultDropped), 64'(1));
      sumReady = 1;
      idle(8);
      checkValue("drain entries", 64'(seenQ.size()), 64'(4));
      for (int i = 0; i < 4; i++) checkSeen("drain", i, 64'(1) << i, 1, 0, 0);

      // ECC mid-batch, on the closing beat's stage-2 cycle, then clean
      seenQ.delete();
      beat(1, 1, 0, 0); beat(0, 0, 0, 1); beat(1, 2, 1, 0);
      idle(3);
      beat(1, 3, 0, 0); beat(1, 4, 1, 0); beat(0, 0, 0, 0); beat(0, 0, 0, 1);
      idle(3);
      beat(1, 5, 1, 0);
      idle(6);
      checkSeen("ecc mid", 0, 6, 2, 1, 0);
      checkSeen("ecc close", 1, 24, 2, 1, 0);
      checkSeen("ecc clean", 2, 32, 1, 0, 0);

      // Carry-out and out-of-range counts
      seenQ.delete();
      beat(1, SW - 1, 0, 0); beat(1, SW - 1, 1, 0); beat(1, 50, 1, 0); beat(1, 3, 1, 0);
      idle(6);
      checkSeen("ovf carry", 0, 0, 2, 0, OVF_EN);
      checkSeen("ovf bigterm", 1, 0, 1, 0, OVF_EN);
      checkSeen("ovf after", 2, 8, 1, 0, 0);

      // Reset with an open batch and two queued entries
      sumReady = 0;
      beat(1, 1, 1, 0); beat(1, 2, 1, 0);
      idle(3);
      beat(1, 3, 0, 0); beat(1, 4, 0, 0);
      rst = 1'b1;
      #1;
      checkValue("rst sumValid", 64'(sumValid), 64'(0));
      checkValue("rst sumOut", 64'(sumOut), 64'(0));
      checkValue("rst botCount", 64'(botCountOut), 64'(0));
      checkValue("rst ecc", 64'(eccErrorOut), 64'(0));
      checkValue("rst ovf", 64'(overflowOut), 64'(0));
      checkValue("rst nearlyFull", 64'(nearlyFull), 64'(0));
      checkValue("rst dropped", 64'(resultDropped), 64'(0));
      modelClear();
      @(posedge clk);
      #1 rst = 1'b0;
      sumReady = 1; seenQ.delete();
      beat(1, 4, 1, 0);
      idle(5);
      checkValue("post-rst entries", 64'(seenQ.size()), 64'(1));
      checkSeen("post-rst", 0, 16, 1, 0, 0);

      // Random traffic with bursty backpressure
      mode = 1;
      for (int c = 0; c < 3000; c++) begin
         if (c % 64 == 0) mode = int'($urandom_range(0, 2));
         sumReady = (mode != 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
         beat($urandom_range(0, 3) != 0,
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 63)) : int'($urandom_range(0, 12)),
              $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      end
      sumReady = 1;
      idle(12);
      checkValue("final drained", 64'(fifoQ.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
